cpu_control_fsm: RTL

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/cpu_decoder.sv | 65 ++++++
 rtl/cpu_control_fsm.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the CPU control slice.
//   * state_e   : controller state encoding (FETCH/DECODE/EXEC/WB)
//   * alu_op_e  : ALU SELECT encodings driven on ALUOP
//   * OP_*      : opcode values found in instruction bits [31:24]
//   * EXEC_*    : EXEC-phase latencies in cycles
//   * ctrl_t    : decoded control bundle produced by cpu_decoder
//   * exec_cycles() : EXEC latency for a decoded operation
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_FWD  = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_MULT = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHA  = 3'b110,
        ALU_ROR  = 3'b111
    } alu_op_e;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_MULT  = 8'h08;
    localparam logic [7:0] OP_SL    = 8'h09;
    localparam logic [7:0] OP_SA    = 8'h0A;
    localparam logic [7:0] OP_ROR   = 8'h0B;

    localparam logic [1:0] EXEC_SHORT = 2'd1;
    localparam logic [1:0] EXEC_LONG  = 2'd2;

    typedef struct packed {
        alu_op_e    aluop;
        logic       imm_sel;
        logic       neg_sel;
        logic       reg_write;
        logic       is_jump;
        logic       is_branch;
        logic       illegal;
        logic [1:0] exec_len;
    } ctrl_t;

    // Pass-through and simple logic ops (and jumps, which bypass the ALU)
    // finish in one EXEC cycle; arithmetic, multiply and shifts take two.
    function automatic logic [1:0] exec_cycles(input alu_op_e op, input logic is_jump);
        logic [1:0] len;
        len = EXEC_LONG;
        if (is_jump || op == ALU_FWD || op == ALU_AND || op == ALU_OR) begin
            len = EXEC_SHORT;
        end
        return len;
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// ---------------------------------------------------------------------------
// cpu_decoder -- purely combinational opcode-to-control decode.
// Ports:
//   opcode : in  [7:0]  instruction bits [31:24]
//   ctrl   : out ctrl_t ALU select, operand selects, write strobe, flow
//                       control flags, illegal flag and EXEC latency
// ---------------------------------------------------------------------------
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no opcode
        // path can leave an output unassigned and infer a latch.
        ctrl           = '0;
        ctrl.aluop     = ALU_FWD;
        ctrl.reg_write = 1'b1;

        case (opcode)
            OP_LOADI: ctrl.imm_sel = 1'b1;
            OP_MOV:   ctrl.aluop   = ALU_FWD;
            OP_ADD:   ctrl.aluop   = ALU_ADD;
            OP_SUB: begin
                ctrl.aluop   = ALU_ADD;
                ctrl.neg_sel = 1'b1;
            end
            OP_AND:   ctrl.aluop   = ALU_AND;
            OP_OR:    ctrl.aluop   = ALU_OR;
            OP_J: begin
                ctrl.reg_write = 1'b0;
                ctrl.is_jump   = 1'b1;
            end
            // beq is a compare: subtract and let the ALU zero flag decide.
            OP_BEQ: begin
                ctrl.aluop     = ALU_ADD;
                ctrl.neg_sel   = 1'b1;
                ctrl.reg_write = 1'b0;
                ctrl.is_branch = 1'b1;
            end
            OP_MULT:  ctrl.aluop   = ALU_MULT;
            OP_SL: begin
                ctrl.aluop   = ALU_SHL;
                ctrl.imm_sel = 1'b1;
            end
            OP_SA: begin
                ctrl.aluop   = ALU_SHA;
                ctrl.imm_sel = 1'b1;
            end
            OP_ROR: begin
                ctrl.aluop   = ALU_ROR;
                ctrl.imm_sel = 1'b1;
            end
            default: begin
                ctrl.reg_write = 1'b0;
                ctrl.illegal   = 1'b1;
            end
        endcase

        ctrl.exec_len = exec_cycles(ctrl.aluop, ctrl.is_jump);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm -- multi-cycle CPU controller: FETCH -> DECODE -> EXEC -> WB.
// Ports:
//   clk          : in   system clock, rising edge
//   reset        : in   asynchronous reset, active LOW
//   instruction  : in   [ILEN-1:0] instruction word (fields in bits [31:0])
//   instr_valid  : in   instruction memory presents a word for the current pc
//   zero         : in   ALU zero flag, sampled on the last EXEC cycle of beq
//   pc           : out  [PC_WIDTH-1:0] address being fetched/executed
//   instr_ready  : out  controller accepts instruction this cycle
//   aluop        : out  [2:0] ALU select
//   readreg1/2   : out  [2:0] source register addresses ([10:8], [2:0])
//   writereg     : out  [2:0] destination register address ([18:16])
//   immediate    : out  [7:0] instruction bits [7:0]
//   imm_sel      : out  ALU DATA2 takes immediate
//   neg_sel      : out  ALU DATA2 is negated (two's complement)
//   writeenable  : out  register-file write strobe (WB only)
//   illegal      : out  one-cycle pulse in DECODE for an undefined opcode
// All outputs are registers or direct slices of the latched instruction.
// ---------------------------------------------------------------------------
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int ILEN     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ILEN-1:0]     instruction,
    input  logic                instr_valid,
    input  logic                zero,
    output logic [PC_WIDTH-1:0] pc,
    output logic                instr_ready,
    output logic [2:0]          aluop,
    output logic [2:0]          readreg1,
    output logic [2:0]          readreg2,
    output logic [2:0]          writereg,
    output logic [7:0]          immediate,
    output logic                imm_sel,
    output logic                neg_sel,
    output logic                writeenable,
    output logic                illegal
);

    state_e        state;
    logic [31:0]   instr_q;
    logic          reg_write_q;
    logic          is_jump_q;
    logic          is_branch_q;
    logic          take_branch;
    logic [1:0]    exec_cnt;
    ctrl_t         dec;

    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] branch_off;

    // Decode the word on the bus so the control registers are already valid
    // during the DECODE cycle that follows the accepting edge.
    cpu_decoder u_decoder (
        .opcode (instruction[31:24]),
        .ctrl   (dec)
    );

    assign readreg1  = instr_q[10:8];
    assign readreg2  = instr_q[2:0];
    assign writereg  = instr_q[18:16];
    assign immediate = instr_q[7:0];

    // Branch offset counts words: sign-extend the byte, then scale by 4.
    assign pc_seq     = pc + PC_WIDTH'(4);
    assign branch_off = {{(PC_WIDTH-10){instr_q[23]}}, instr_q[23:16], 2'b00};

    // Opcode and bits [15:11] are carried in the latched word but not used
    // after decode.
    logic unused_fields;
    assign unused_fields = ^{instr_q[31:24], instr_q[15:11]};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Reset aborts any instruction in flight: no write, no pc update.
            state       <= ST_FETCH;
            pc          <= '0;
            instr_q     <= '0;
            aluop       <= ALU_FWD;
            imm_sel     <= 1'b0;
            neg_sel     <= 1'b0;
            writeenable <= 1'b0;
            illegal     <= 1'b0;
            instr_ready <= 1'b0;
            reg_write_q <= 1'b0;
            is_jump_q   <= 1'b0;
            is_branch_q <= 1'b0;
            take_branch <= 1'b0;
            exec_cnt    <= '0;
        end else begin
            illegal <= 1'b0;

            case (state)
                ST_FETCH: begin
                    instr_ready <= 1'b1;
                    if (instr_ready && instr_valid) begin
                        instr_q     <= instruction[31:0];
                        aluop       <= dec.aluop;
                        imm_sel     <= dec.imm_sel;
                        neg_sel     <= dec.neg_sel;
                        illegal     <= dec.illegal;
                        reg_write_q <= dec.reg_write;
                        is_jump_q   <= dec.is_jump;
                        is_branch_q <= dec.is_branch;
                        exec_cnt    <= dec.exec_len - 2'd1;
                        instr_ready <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end

                ST_DECODE: state <= ST_EXEC;

                ST_EXEC: begin
                    if (exec_cnt == '0) begin
                        // Last EXEC cycle: the ALU result (and zero flag) is final.
                        take_branch <= is_jump_q | (is_branch_q & zero);
                        writeenable <= reg_write_q;
                        state       <= ST_WB;
                    end else begin
                        exec_cnt <= exec_cnt - 2'd1;
                    end
                end

                ST_WB: begin
                    pc          <= take_branch ? pc_seq + branch_off : pc_seq;
                    writeenable <= 1'b0;
                    imm_sel     <= 1'b0;
                    neg_sel     <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= ST_FETCH;
                end

                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
